// File: rtl/uram_port_arbiter.sv
// uram_port_arbiter: round-robin sharing of one single-port UltraRAM among NREQ requesters,
// with an optional zero sweep after reset. Define URAM_ARB_WACK_EN to get write responses.
module uram_port_arbiter #(
    parameter int  NREQ           = 4,
    parameter int  AWIDTH         = 12,
    parameter int  DWIDTH         = 72,
    parameter int  CLEAR_ON_RESET = 1,
    localparam int IDW            = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid_i,
    output logic [NREQ-1:0]          req_ready_o,
    input  logic [NREQ-1:0]          req_we_i,
    input  logic [NREQ*AWIDTH-1:0]   req_addr_i,
    input  logic [NREQ*DWIDTH-1:0]   req_wdata_i,
    output logic                     rsp_valid_o,
    input  logic                     rsp_ready_i,
    output logic [IDW-1:0]           rsp_id_o,
    output logic [DWIDTH-1:0]        rsp_data_o,
`ifdef URAM_ARB_WACK_EN
    output logic                     rsp_is_wr_o,
`endif
    output logic                     init_done_o,
    output logic                     mem_en_o,
    output logic                     mem_we_o,
    output logic [AWIDTH-1:0]        mem_waddr_o,
    output logic [AWIDTH-1:0]        mem_raddr_o,
    output logic [DWIDTH-1:0]        mem_din_o,
    input  logic [DWIDTH-1:0]        mem_dout_i
);

    typedef enum logic {ST_INIT = 1'b0, ST_RUN = 1'b1} state_e;

    localparam state_e      RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_INIT : ST_RUN;
    localparam logic [IDW:0] NREQ_W     = (IDW + 1)'(NREQ);

    // Modulo-NREQ addition of two indices that are each already below NREQ.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] a, input logic [IDW-1:0] b);
        logic [IDW:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum >= NREQ_W) ? IDW'(sum - NREQ_W) : IDW'(sum);
    endfunction

    state_e              state_q, state_d;
    logic [AWIDTH-1:0]   sweep_q, sweep_d;
    logic [IDW-1:0]      rr_ptr_q, rr_ptr_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]      rsp_id_q, rsp_id_d;
    logic [DWIDTH-1:0]   rsp_data_q, rsp_data_d;
`ifdef URAM_ARB_WACK_EN
    logic                rsp_is_wr_q, rsp_is_wr_d;
`endif

    logic                run_s;
    logic                slot_free_s;
    logic [NREQ-1:0]     eligible_s;
    logic [2*NREQ-1:0]   elig_dbl_s;
    logic [NREQ-1:0]     elig_rot_s;
    logic [IDW-1:0]      first_s;
    logic                grant_s;
    logic [IDW-1:0]      grant_idx_s;
    logic                grant_we_s;
    logic [AWIDTH-1:0]   grant_addr_s;
    logic [DWIDTH-1:0]   grant_wdata_s;
    logic                rsp_load_s;
    logic [DWIDTH-1:0]   rsp_load_data_s;

    assign run_s       = (state_q == ST_RUN);
    assign slot_free_s = ~rsp_valid_q | rsp_ready_i;

    // A read may only win when the response slot is empty or draining this cycle.
    always_comb begin
        eligible_s = {NREQ{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
`ifdef URAM_ARB_WACK_EN
            eligible_s[i] = run_s & req_valid_i[i] & slot_free_s;
`else
            eligible_s[i] = run_s & req_valid_i[i] & (req_we_i[i] | slot_free_s);
`endif
        end
    end

    assign elig_dbl_s = {eligible_s, eligible_s} >> rr_ptr_q;
    assign elig_rot_s = elig_dbl_s[NREQ-1:0];

    // Rotate so rr_ptr sits at bit 0, take the lowest set bit, then rotate back.
    always_comb begin
        first_s = {IDW{1'b0}};
        for (int j = NREQ - 1; j >= 0; j--) begin
            first_s = elig_rot_s[j] ? IDW'(j) : first_s;
        end
        grant_s     = |elig_rot_s;
        grant_idx_s = wrap_add(rr_ptr_q, first_s);
    end

    // Pick the winning requester's command fields.
    always_comb begin
        grant_we_s    = 1'b0;
        grant_addr_s  = {AWIDTH{1'b0}};
        grant_wdata_s = {DWIDTH{1'b0}};
        for (int i = 0; i < NREQ; i++) begin
            grant_we_s    = (grant_idx_s == IDW'(i)) ? req_we_i[i]                     : grant_we_s;
            grant_addr_s  = (grant_idx_s == IDW'(i)) ? req_addr_i[i*AWIDTH +: AWIDTH]  : grant_addr_s;
            grant_wdata_s = (grant_idx_s == IDW'(i)) ? req_wdata_i[i*DWIDTH +: DWIDTH] : grant_wdata_s;
        end
    end

`ifdef URAM_ARB_WACK_EN
    assign rsp_load_s      = grant_s;
    assign rsp_load_data_s = grant_we_s ? grant_wdata_s : mem_dout_i;
`else
    assign rsp_load_s      = grant_s & ~grant_we_s;
    assign rsp_load_data_s = mem_dout_i;
`endif

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= RESET_STATE;
            sweep_q     <= {AWIDTH{1'b0}};
            rr_ptr_q    <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= {IDW{1'b0}};
            rsp_data_q  <= {DWIDTH{1'b0}};
`ifdef URAM_ARB_WACK_EN
            rsp_is_wr_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sweep_q     <= sweep_d;
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
`ifdef URAM_ARB_WACK_EN
            rsp_is_wr_q <= rsp_is_wr_d;
`endif
        end
    end

    // Next-state: sweep progress, pointer rotation, response slot load/pop.
    always_comb begin
        state_d     = state_q;
        sweep_d     = sweep_q;
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
`ifdef URAM_ARB_WACK_EN
        rsp_is_wr_d = rsp_is_wr_q;
`endif
        case (state_q)
            ST_INIT: begin
                sweep_d = sweep_q + AWIDTH'(1'b1);
                if (sweep_q == {AWIDTH{1'b1}}) begin
                    state_d = ST_RUN;
                end else begin
                    state_d = ST_INIT;
                end
            end
            ST_RUN: begin
                if (grant_s) begin
                    rr_ptr_d = wrap_add(grant_idx_s, IDW'(1'b1));
                end else begin
                    rr_ptr_d = rr_ptr_q;
                end
                // A new load wins over a pop so back-to-back reads leave no bubble.
                if (rsp_load_s) begin
                    rsp_valid_d = 1'b1;
                    rsp_id_d    = grant_idx_s;
                    rsp_data_d  = rsp_load_data_s;
`ifdef URAM_ARB_WACK_EN
                    rsp_is_wr_d = grant_we_s;
`endif
                end else if (rsp_valid_q & rsp_ready_i) begin
                    rsp_valid_d = 1'b0;
                end else begin
                    rsp_valid_d = rsp_valid_q;
                end
            end
            default: begin
                state_d = RESET_STATE;
            end
        endcase
    end

    // Outputs decoded from state and the current grant.
    always_comb begin
        req_ready_o = {NREQ{1'b0}};
        mem_en_o    = 1'b0;
        mem_we_o    = 1'b0;
        mem_waddr_o = {AWIDTH{1'b0}};
        mem_raddr_o = {AWIDTH{1'b0}};
        mem_din_o   = {DWIDTH{1'b0}};
        case (state_q)
            ST_INIT: begin
                mem_en_o    = 1'b1;
                mem_we_o    = 1'b1;
                mem_waddr_o = sweep_q;
                mem_raddr_o = sweep_q;
            end
            ST_RUN: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ready_o[i] = grant_s & (grant_idx_s == IDW'(i));
                end
                mem_en_o    = grant_s;
                mem_we_o    = grant_s & grant_we_s;
                mem_waddr_o = grant_addr_s;
                mem_raddr_o = grant_addr_s;
                mem_din_o   = grant_wdata_s;
            end
            default: begin
                mem_en_o = 1'b0;
            end
        endcase
    end

    assign rsp_valid_o = rsp_valid_q;
    assign rsp_id_o    = rsp_id_q;
    assign rsp_data_o  = rsp_data_q;
    assign init_done_o = run_s;
`ifdef URAM_ARB_WACK_EN
    assign rsp_is_wr_o = rsp_is_wr_q;
`endif

endmodule

// File: tb/tb_uram_port_arbiter.sv
// tb_uram_port_arbiter: directed table, hand sequences and random traffic checked against
// a cycle-level behavioural model of the arbiter and an independent RAM image.
module tb_uram_port_arbiter;

    localparam int NREQ  = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int DEPTH = 16;

    logic               clk = 1'b0;
    logic               rst_n = 1'b1;
    logic [NREQ-1:0]    req_valid, req_we, req_ready;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic               rsp_valid, rsp_ready;
    logic [1:0]         rsp_id;
    logic [DW-1:0]      rsp_data;
`ifdef URAM_ARB_WACK_EN
    logic               rsp_is_wr;
`endif
    logic               init_done, mem_en, mem_we;
    logic [AW-1:0]      mem_waddr, mem_raddr;
    logic [DW-1:0]      mem_din, mem_dout;

    logic [DW-1:0]      ram [DEPTH];
    logic               poison = 1'b1;

    int total = 0;
    int bad   = 0;

    // reference model state
    bit            m_init;
    int            m_sweep, m_ptr, m_rid, last_g;
    bit            m_rv, m_rwr;
    logic [DW-1:0] m_rdata;
    logic [DW-1:0] m_mem [DEPTH];

    typedef struct {
        logic [3:0] valid;
        logic [3:0] we;
        logic       rdy;
        logic [3:0] exp_ready;
        logic       exp_rv;
        logic [1:0] exp_rid;
    } vec_t;
    vec_t vecs [13];

    always #5 clk = ~clk;

    uram_port_arbiter #(.NREQ(NREQ), .AWIDTH(AW), .DWIDTH(DW), .CLEAR_ON_RESET(1)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_we_i(req_we),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_id_o(rsp_id), .rsp_data_o(rsp_data),
`ifdef URAM_ARB_WACK_EN
        .rsp_is_wr_o(rsp_is_wr),
`endif
        .init_done_o(init_done), .mem_en_o(mem_en), .mem_we_o(mem_we),
        .mem_waddr_o(mem_waddr), .mem_raddr_o(mem_raddr), .mem_din_o(mem_din), .mem_dout_i(mem_dout)
    );

    // UltraRAM stand-in: combinational read, write at the clock edge, garbage until swept.
    assign mem_dout = ram[mem_raddr];
    always @(posedge clk) begin
        if (poison) begin
            for (int k = 0; k < DEPTH; k++) ram[k] <= 16'hDE00 | 16'(k);
        end else if (mem_en && mem_we) begin
            ram[mem_waddr] <= mem_din;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic set_req(input int i, input bit v, input bit w, input logic [AW-1:0] a,
                           input logic [DW-1:0] d);
        req_valid[i]          = v;
        req_we[i]             = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    // Called right after a falling edge with inputs driven; checks, advances the model,
    // and returns at the next falling edge.
    task automatic step();
        int g, idx;
        bit slot_free, elig;
        logic [AW-1:0] a;
        logic [DW-1:0] wd;
        logic [NREQ-1:0] exp_ready;
        #1;
        check("rsp_valid", 32'(rsp_valid), 32'(m_rv));
        if (m_rv) begin
            check("rsp_id", 32'(rsp_id), 32'(m_rid));
            check("rsp_data", 32'(rsp_data), 32'(m_rdata));
`ifdef URAM_ARB_WACK_EN
            check("rsp_is_wr", 32'(rsp_is_wr), 32'(m_rwr));
`endif
        end
        check("init_done", 32'(init_done), 32'(!m_init));
        if (m_init) begin
            check("init_ready", 32'(req_ready), 32'd0);
            check("init_mem_en", 32'(mem_en & mem_we), 32'd1);
            check("init_waddr", 32'(mem_waddr), 32'(m_sweep));
            check("init_din", 32'(mem_din), 32'd0);
            m_mem[m_sweep] = '0;
            m_sweep++;
            if (m_sweep == DEPTH) m_init = 1'b0;
            last_g = -1;
        end else begin
            slot_free = !m_rv || rsp_ready;
            g = -1;
            for (int d = 0; d < NREQ; d++) begin
                idx = (m_ptr + d) % NREQ;
`ifdef URAM_ARB_WACK_EN
                elig = req_valid[idx] && slot_free;
`else
                elig = req_valid[idx] && (req_we[idx] || slot_free);
`endif
                if (elig && g < 0) g = idx;
            end
            exp_ready = (g >= 0) ? (4'b0001 << g) : 4'b0000;
            check("req_ready", 32'(req_ready), 32'(exp_ready));
            check("mem_en", 32'(mem_en), 32'(g >= 0));
            if (g >= 0) begin
                a  = req_addr[g*AW +: AW];
                wd = req_wdata[g*DW +: DW];
                check("mem_we", 32'(mem_we), 32'(req_we[g]));
                check("mem_waddr", 32'(mem_waddr), 32'(a));
                check("mem_raddr", 32'(mem_raddr), 32'(a));
                if (req_we[g]) begin
                    check("mem_din", 32'(mem_din), 32'(wd));
                    m_mem[a] = wd;
`ifdef URAM_ARB_WACK_EN
                    m_rv = 1'b1; m_rid = g; m_rdata = wd; m_rwr = 1'b1;
`else
                    if (m_rv && rsp_ready) m_rv = 1'b0;
`endif
                end else begin
                    m_rv = 1'b1; m_rid = g; m_rdata = m_mem[a]; m_rwr = 1'b0;
                end
                m_ptr = (g + 1) % NREQ;
            end else begin
                check("mem_we_idle", 32'(mem_we), 32'd0);
                if (m_rv && rsp_ready) m_rv = 1'b0;
            end
            last_g = g;
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_rsp_data", 32'(rsp_data), 32'd0);
        check("rst_init_done", 32'(init_done), 32'd0);
        m_init = 1'b1; m_sweep = 0; m_ptr = 0; m_rv = 1'b0; m_rid = 0; m_rdata = '0;
        m_rwr = 1'b0; last_g = -1;
        repeat (2) @(negedge clk);
        poison = 1'b0;
        rst_n  = 1'b1;
    endtask

    task automatic run_init();
        for (int c = 0; c < DEPTH; c++) begin
            req_valid = 4'($urandom_range(0, 15));
            req_we    = 4'($urandom_range(0, 15));
            rsp_ready = 1'b1;
            step();
        end
        req_valid = '0;
    endtask

    initial begin
        // grants observed per row; rows 0-5 round robin, 6-8 blocked slot, 9-12 wrap
        vecs[0]  = '{4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b0, 2'd0};
`ifdef URAM_ARB_WACK_EN
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
`else
        vecs[1]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b0, 2'd0};
`endif
        vecs[2]  = '{4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
        vecs[3]  = '{4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd1};
        vecs[4]  = '{4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
        vecs[5]  = '{4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
`ifdef URAM_ARB_WACK_EN
        vecs[6]  = '{4'b0110, 4'b0100, 1'b0, 4'b0000, 1'b1, 2'd0};
`else
        vecs[6]  = '{4'b0110, 4'b0100, 1'b0, 4'b0100, 1'b1, 2'd0};
`endif
        vecs[7]  = '{4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, 2'd0};
        vecs[8]  = '{4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, 2'd0};
        vecs[9]  = '{4'b0100, 4'b0100, 1'b1, 4'b0100, 1'b1, 2'd1};
`ifdef URAM_ARB_WACK_EN
        vecs[10] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b1, 2'd2};
`else
        vecs[10] = '{4'b1001, 4'b0000, 1'b1, 4'b1000, 1'b0, 2'd0};
`endif
        vecs[11] = '{4'b1001, 4'b0000, 1'b1, 4'b0001, 1'b1, 2'd3};
        vecs[12] = '{4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b1, 2'd0};

        req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b1;
        #2;
        do_reset();

        // sweep, then every address must read back zero
        run_init();
        for (int a = 0; a < DEPTH; a++) begin
            set_req(0, 1'b1, 1'b0, 4'(a), 16'h0000);
            step();
            #1;
            check("sweep_zero", 32'(rsp_data), 32'd0);
        end
        req_valid = '0;
        step();

        // write then immediate read of the same address
        set_req(0, 1'b1, 1'b1, 4'd5, 16'h00AB);
        step();
        set_req(0, 1'b1, 1'b0, 4'd5, 16'h0000);
        step();
        req_valid = '0;
        #1;
        check("raw_valid", 32'(rsp_valid), 32'd1);
        check("raw_data", 32'(rsp_data), 32'h00AB);
        check("raw_id", 32'(rsp_id), 32'd0);
        step();

        for (int i = 0; i < NREQ; i++) set_req(i, 1'b0, 1'b0, 4'(8 + i), 16'h1000 | 16'(i));
        for (int v = 0; v < 13; v++) begin
            req_valid = vecs[v].valid;
            req_we    = vecs[v].we;
            rsp_ready = vecs[v].rdy;
            #1;
            check($sformatf("vec%0d_ready", v), 32'(req_ready), 32'(vecs[v].exp_ready));
            check($sformatf("vec%0d_rv", v), 32'(rsp_valid), 32'(vecs[v].exp_rv));
            if (vecs[v].exp_rv) check($sformatf("vec%0d_rid", v), 32'(rsp_id), 32'(vecs[v].exp_rid));
            step();
        end

`ifdef URAM_ARB_WACK_EN
        req_valid = '0;
        set_req(2, 1'b1, 1'b1, 4'd3, 16'h0011);
        rsp_ready = 1'b1;
        step();
        req_valid = '0;
        #1;
        check("wack_is_wr", 32'(rsp_is_wr), 32'd1);
        check("wack_id", 32'(rsp_id), 32'd2);
        check("wack_data", 32'(rsp_data), 32'h0011);
        step();
`endif

        // reset in the middle of a read burst
        req_valid = 4'b1111; req_we = 4'b0000; rsp_ready = 1'b1;
        step();
        step();
        do_reset();
        req_valid = '0;
        run_init();

        // random traffic; requesters hold their command until granted
        for (int c = 0; c < 800; c++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < NREQ; i++) begin
                if (!req_valid[i] || last_g == i) begin
                    set_req(i, ($urandom_range(0, 2) != 0), 1'($urandom_range(0, 1)),
                            4'($urandom_range(0, DEPTH - 1)), 16'($urandom));
                end
            end
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
